xnor_popcnt_acc_i8: RTL

- Downstream consumer of the xnor_i8_i8_i8 stage for binary-dot-product datapaths.
- Takes a stream of 8-bit xnor results, popcounts each beat, and accumulates LEN beats into one dot-product sum.
- Emits the sum and a signed bipolar score through a valid/ready handshake with a one-entry output register.

---
 rtl/xnor_pkg.sv | 18 +
 rtl/popcount8.sv | 18 +
 rtl/xnor_popcnt_acc_i8.sv | 103 ++++++++++
 3 files changed

// File: rtl/xnor_pkg.sv
// Shared definitions for the xnor binary-dot-product datapath blocks.
//   POPCNT_W     : width of an 8-bit popcount result (0..8)
//   state_t      : output-register state; the state bit doubles as out_valid
//   score_offset : bipolar score offset (8 bits per beat times beats per vector)
package xnor_pkg;

    localparam int POPCNT_W = 4;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int score_offset(input int len);
        return 8 * len;
    endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational popcount of an 8-bit word.
//   y  : input word
//   pc : number of set bits in y, 0..8
module popcount8
    import xnor_pkg::*;
(
    input  logic [7:0]          y,
    output logic [POPCNT_W-1:0] pc
);

    always_comb begin
        pc = '0;
        for (int i = 0; i < 8; i++) begin
            pc = pc + POPCNT_W'(y[i]);
        end
    end

endmodule

// File: rtl/xnor_popcnt_acc_i8.sv
// Popcount accumulator for binary dot products: sums popcount(in_y) over LEN
// accepted beats and presents the sum plus its bipolar score through a
// one-entry valid/ready output register.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : in_y carries a beat
//   in_ready  : beat is accepted this cycle
//   in_y      : 8-bit xnor result from the upstream stage
//   out_valid : out_sum/out_score hold a result
//   out_ready : consumer takes the result
//   out_sum   : sum of popcounts over LEN beats (unsigned)
//   out_score : 2*out_sum - 8*LEN (two's complement)
module xnor_popcnt_acc_i8
    import xnor_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum,
    output logic signed [ACC_W:0]   out_score
);

    localparam int                CNT_W     = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(LEN - 1);
    localparam int                SCORE_OFS = score_offset(LEN);

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;

    logic [7:0]           y_p0;
    logic [POPCNT_W-1:0]  pc_p0;
    logic [ACC_W-1:0]     sum_p0;
    logic                 last_beat;
    logic                 take;
    logic                 final_take;
    logic                 out_take;

    // 2*sum - offset, formed two bits wider so the doubling cannot wrap
    // before the offset is removed; the result always fits ACC_W+1 bits.
    function automatic logic signed [ACC_W:0] to_score(input logic [ACC_W-1:0] s);
        logic signed [ACC_W+1:0] wide;
        wide = $signed({1'b0, s, 1'b0}) - $signed((ACC_W+2)'(SCORE_OFS));
        return $signed(wide[ACC_W:0]);
    endfunction

    // ---- stage p0: gate, popcount, add (combinational) ----
    // Idle beats are forced to zero so an undriven in_y never reaches the adder.
    assign y_p0 = in_valid ? in_y : 8'h00;

    popcount8 u_popcount8 (
        .y  (y_p0),
        .pc (pc_p0)
    );

    assign sum_p0    = acc + ACC_W'(pc_p0);
    assign last_beat = (cnt == LAST);
    assign out_valid = (state == EMIT);

    // Only the final beat has to wait for the output register to drain.
    assign in_ready   = (state == ACC) | ~last_beat | out_ready;
    assign take       = in_valid & in_ready;
    assign final_take = take & last_beat;
    assign out_take   = out_valid & out_ready;

    // ---- stage p1: accumulator and output register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_score <= '0;
        end else begin
            if (take) begin
                if (last_beat) begin
                    acc       <= '0;
                    cnt       <= '0;
                    out_sum   <= sum_p0;
                    out_score <= to_score(sum_p0);
                end else begin
                    acc <= sum_p0;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A final beat landing together with a drain reloads the register
            // and stays in EMIT, so back-to-back results have no bubble.
            if (final_take) begin
                state <= EMIT;
            end else if (out_take) begin
                state <= ACC;
            end
        end
    end

endmodule
